ram_master: RTL and testbench

- Initiator-side burst controller for the single-port 32x32 synchronous RAM.
- Accepts one burst command (read or write, start address, length) over a valid/ready handshake.
- Sequences the RAM's cen/wen/S_addr/S_din pins one word per cycle.
- Streams write data in and read data out. Sits between the ALU/multiplier datapath and the RAM.

---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_master_addr_gen.sv | 45 ++++
 rtl/ram_master.sv | 135 +++++++++++++
 tb/tb_ram_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types for the ram_master burst controller: default widths,
// FSM state encoding and the burst command record.
package ram_pkg;

   localparam int AW_DEF = 5;
   localparam int DW_DEF = 32;
   localparam int LW_DEF = 5;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_WR     = 3'd1;
   localparam state_t S_RD     = 3'd2;
   localparam state_t S_DRAIN  = 3'd3;
   localparam state_t S_DONE   = 3'd4;
   localparam state_t S_VRD    = 3'd5;
   localparam state_t S_VDRAIN = 3'd6;

   typedef struct packed {
      logic              wr;
      logic [AW_DEF-1:0] addr;
      logic [LW_DEF-1:0] len;
   } cmd_t;

endpackage

// File: rtl/ram_master_addr_gen.sv
// Burst address/count generator: loads start address and length, steps with
// modulo-2^AW wrap, and can replay the same range for a second pass.
module ram_master_addr_gen #(
   parameter int AW = 5,
   parameter int LW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [AW-1:0] load_addr,
   input  logic [LW-1:0] load_len,
   input  logic          reload,
   input  logic          step,
   output logic [AW-1:0] addr,
   output logic          last
);

   logic [AW-1:0] start_q;
   logic [LW-1:0] len_q;
   logic [LW-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q <= '0;
         len_q   <= '0;
         addr    <= '0;
         cnt_q   <= '0;
      end else if (load) begin
         start_q <= load_addr;
         len_q   <= load_len;
         addr    <= load_addr;
         cnt_q   <= load_len;
      end else if (reload) begin
         addr  <= start_q;
         cnt_q <= len_q;
      end else if (step) begin
         addr  <= addr + 1'b1;
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Count holds words remaining minus one, so zero marks the final word.
   assign last = (cnt_q == '0);

endmodule

// File: rtl/ram_master.sv
// ram_master: burst initiator for the single-port synchronous RAM.
// Define RAM_MASTER_VERIFY_EN to add the write read-back verify pass and err.
module ram_master
   import ram_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter int LW = LW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wr,
   input  logic [AW-1:0] req_addr,
   input  logic [LW-1:0] req_len,
   input  logic [DW-1:0] wdata,
   input  logic          wvalid,
   output logic          wready,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          busy,
   output logic          done,
   output logic          cen,
   output logic          wen,
   output logic [AW-1:0] S_addr,
   output logic [DW-1:0] S_din,
   input  logic [DW-1:0] S_dout
`ifdef RAM_MASTER_VERIFY_EN
   ,
   output logic          err
`endif
);

   state_t        state;
   state_t        state_nx;
   cmd_t          cmd;
   logic          accept;
   logic          wr_fire;
   logic          rd_issue;
   logic          vrd_issue;
   logic          reload;
   logic          last;
   logic [AW-1:0] addr;
   logic          rd_vld_p1;

   assign cmd      = '{wr: req_wr, addr: req_addr, len: req_len};
   assign accept   = (state == S_IDLE) && req_valid;
   assign wr_fire  = (state == S_WR) && wvalid;
   assign rd_issue = (state == S_RD);

`ifdef RAM_MASTER_VERIFY_EN
   assign vrd_issue = (state == S_VRD);
   assign reload    = wr_fire && last;
`else
   assign vrd_issue = 1'b0;
   assign reload    = 1'b0;
`endif

   ram_master_addr_gen #(.AW(AW), .LW(LW)) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .load_addr (cmd.addr),
      .load_len  (cmd.len),
      .reload    (reload),
      .step      (wr_fire || rd_issue || vrd_issue),
      .addr      (addr),
      .last      (last)
   );

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (req_valid) state_nx = cmd.wr ? S_WR : S_RD;
`ifdef RAM_MASTER_VERIFY_EN
         S_WR:     if (wvalid && last) state_nx = S_VRD;
         S_VRD:    if (last) state_nx = S_VDRAIN;
         S_VDRAIN: state_nx = S_DONE;
`else
         S_WR:     if (wvalid && last) state_nx = S_DONE;
`endif
         S_RD:     if (last) state_nx = S_DRAIN;
         S_DRAIN:  state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         rd_vld_p1 <= 1'b0;
      end else begin
         state     <= state_nx;
         rd_vld_p1 <= rd_issue;
      end
   end

   // Stage p1: RAM returns the word one cycle after its issue.
   assign rvalid    = rd_vld_p1;
   assign rdata     = rd_vld_p1 ? S_dout : '0;

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign wready    = (state == S_WR);
   assign cen       = wr_fire || rd_issue || vrd_issue;
   assign wen       = wr_fire;
   assign S_addr    = cen ? addr : '0;
   assign S_din     = wr_fire ? wdata : '0;

`ifdef RAM_MASTER_VERIFY_EN
   logic [DW-1:0] shadow [2**AW];
   logic [DW-1:0] exp_p1;
   logic          vrd_vld_p1;

   always_ff @(posedge clk) begin
      if (wr_fire) shadow[addr] <= wdata;
      exp_p1 <= shadow[addr];
   end

   // Stage p1: compare the returned verify word with what was written there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vrd_vld_p1 <= 1'b0;
         err        <= 1'b0;
      end else begin
         vrd_vld_p1 <= vrd_issue;
         if (vrd_vld_p1 && (|(S_dout ^ exp_p1))) err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master with a behavioural RAM and a word-array
// reference model of the expected pin activity and read data.
module tb_ram_master;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_wr;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_len;
   logic [DW-1:0] wdata;
   logic          wvalid, wready;
   logic [DW-1:0] rdata;
   logic          rvalid, busy, done, cen, wen;
   logic [AW-1:0] S_addr;
   logic [DW-1:0] S_din, S_dout;
`ifdef RAM_MASTER_VERIFY_EN
   logic          err;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ram     [32];
   logic [DW-1:0] mem_ref [32];
   logic [DW-1:0] dout_q;
   logic          flip = 1'b0;

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [4:0]  len;
      int          mode;
      logic [7:0]  pat;
      logic [31:0] base;
      int          exp_done;
   } vec_t;

   always #5 clk = ~clk;

   ram_master #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wdata     (wdata),
      .wvalid    (wvalid),
      .wready    (wready),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .busy      (busy),
      .done      (done),
      .cen       (cen),
      .wen       (wen),
      .S_addr    (S_addr),
      .S_din     (S_din),
      .S_dout    (S_dout)
`ifdef RAM_MASTER_VERIFY_EN
      ,
      .err       (err)
`endif
   );

   // Behavioural single-port RAM with a registered read port.
   always @(posedge clk) begin
      if (cen) begin
         if (wen) ram[S_addr] <= S_din;
         else     dout_q <= ram[S_addr];
      end
   end
   assign S_dout = dout_q ^ {{(DW-1){1'b0}}, flip};

   function automatic int wx(input int l);
`ifdef RAM_MASTER_VERIFY_EN
      return l + 2;
`else
      return 0 * l;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   // One burst: handshake in cycle 0, then check every cycle until done.
   task automatic burst(input logic wr, input logic [4:0] a, input logic [4:0] l,
                        input int mode, input logic [7:0] pat, input logic [31:0] base,
                        input int exp_done);
      logic [DW-1:0] data [$];
      int            n, last_c, done_c, want;
      logic          prev_iss, wv, exp_cen, exp_wen;
      logic [4:0]    prev_addr, exp_addr;
      logic [31:0]   exp_din;
      n = 0; last_c = -1; done_c = -1; prev_iss = 1'b0; prev_addr = '0;
      for (int i = 0; i <= int'(l); i++)
         data.push_back(base == 0 ? $urandom : 32'(base + 32'(i)));
      step();
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_len = l; wvalid = 1'b0;
      samp();
      chk("req_ready_idle", {31'b0, req_ready}, 1);
      for (int c = 1; c < 200 && done_c < 0; c++) begin
         step();
         req_valid = 1'b0;
         wv = 1'b0;
         if (wr && n <= int'(l)) begin
            case (mode)
               0:       wv = 1'b1;
               1:       wv = (c <= 8) ? pat[c-1] : 1'b1;
               default: wv = 1'($urandom_range(0, 1));
            endcase
         end
         wvalid = wv;
         wdata  = wv ? data[n] : $urandom;
         samp();
         exp_cen = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_din = '0;
         if (wr) begin
            if (wv) begin
               exp_cen = 1'b1; exp_wen = 1'b1; exp_addr = 5'(int'(a) + n); exp_din = data[n];
            end
`ifdef RAM_MASTER_VERIFY_EN
            if (last_c >= 0 && c - last_c <= int'(l) + 1) begin
               exp_cen = 1'b1; exp_addr = 5'(int'(a) + c - last_c - 1);
            end
`endif
         end else if (n <= int'(l)) begin
            exp_cen = 1'b1; exp_addr = 5'(int'(a) + n);
         end
         want = (last_c < 0) ? 0 : (c == last_c + (wr ? 1 + wx(int'(l)) : 2)) ? 1 : 0;
         chk("cen", {31'b0, cen}, {31'b0, exp_cen});
         chk("wen", {31'b0, wen}, {31'b0, exp_wen});
         if (exp_cen) chk("S_addr", {27'b0, S_addr}, {27'b0, exp_addr});
         if (exp_wen) chk("S_din", S_din, exp_din);
         chk("wready", {31'b0, wready}, {31'b0, (wr && n <= int'(l))});
         chk("rvalid", {31'b0, rvalid}, {31'b0, prev_iss});
         if (prev_iss) chk("rdata", rdata, mem_ref[prev_addr]);
         chk("done", {31'b0, done}, want);
         chk("busy", {31'b0, busy}, 1);
         if (done) done_c = c;
         prev_iss  = !wr && exp_cen;
         prev_addr = exp_addr;
         if (exp_cen && n <= int'(l)) begin
            if (wr) mem_ref[exp_addr] = data[n];
            n++;
            if (n == int'(l) + 1) last_c = c;
         end
      end
      chk("done_seen", {31'b0, (done_c > 0)}, 1);
      if (exp_done > 0) chk("done_cycle", done_c, exp_done);
      step();
      samp();
      chk("busy_after", {31'b0, busy}, 0);
      chk("ready_after", {31'b0, req_ready}, 1);
      chk("done_once", {31'b0, done}, 0);
   endtask

   task automatic busy_hold();
      int cen_n, done_n;
      cen_n = 0; done_n = 0;
      step();
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'd4; req_len = 5'd3;
      samp();
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 1) begin req_addr = 5'd10; req_len = 5'd0; end
         samp();
         chk("hold_ready", {31'b0, req_ready}, {31'b0, (c == 7)});
      end
      for (int c = 8; c <= 15; c++) begin
         step();
         req_valid = 1'b0;
         samp();
         if (cen) begin cen_n++; chk("hold_addr", {27'b0, S_addr}, 10); end
         if (rvalid) chk("hold_rdata", rdata, mem_ref[10]);
         if (done) begin done_n++; chk("hold_done_cycle", c, 10); end
      end
      chk("hold_issues", cen_n, 1);
      chk("hold_dones", done_n, 1);
   endtask

   task automatic reset_mid();
      step();
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'd0; req_len = 5'd7;
      samp();
      step(); req_valid = 1'b0; samp();
      step(); samp();
      step();
      #2;
      chk("rst_cen_before", {31'b0, cen}, 1);
      chk("rst_rvalid_before", {31'b0, rvalid}, 1);
      reset = 1'b1;
      #1;
      chk("rst_cen", {31'b0, cen}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_rvalid", {31'b0, rvalid}, 0);
      chk("rst_ready", {31'b0, req_ready}, 1);
      step();
      samp();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step(); samp();
         chk("rst_no_done", {31'b0, done}, 0);
         chk("rst_idle_cen", {31'b0, cen}, 0);
      end
      burst(1'b0, 5'd5, 5'd0, 0, 8'h0, 32'h0, 3);
   endtask

   vec_t vecs [10];

   initial begin
      vecs[0] = '{1'b1, 5'd7,  5'd31, 0, 8'h00, 32'h0,  33 + wx(31)};
      vecs[1] = '{1'b0, 5'd7,  5'd31, 0, 8'h00, 32'h0,  34};
      vecs[2] = '{1'b1, 5'd4,  5'd3,  0, 8'h00, 32'hA0, 5 + wx(3)};
      vecs[3] = '{1'b0, 5'd4,  5'd3,  0, 8'h00, 32'h0,  6};
      vecs[4] = '{1'b1, 5'd30, 5'd3,  0, 8'h00, 32'h1,  5 + wx(3)};
      vecs[5] = '{1'b0, 5'd30, 5'd3,  0, 8'h00, 32'h0,  6};
      vecs[6] = '{1'b1, 5'd0,  5'd0,  0, 8'h00, 32'h0,  2 + wx(0)};
      vecs[7] = '{1'b0, 5'd0,  5'd0,  0, 8'h00, 32'h0,  3};
      vecs[8] = '{1'b1, 5'd9,  5'd2,  1, 8'h19, 32'h0,  6 + wx(2)};
      vecs[9] = '{1'b0, 5'd9,  5'd2,  0, 8'h00, 32'h0,  5};

      for (int i = 0; i < 32; i++) begin ram[i] = '0; mem_ref[i] = '0; end
      reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
      wdata = '0; wvalid = 1'b0;
      step(); step();
      samp();
      chk("rst_req_ready", {31'b0, req_ready}, 1);
      chk("rst_busy0", {31'b0, busy}, 0);
      chk("rst_cen0", {31'b0, cen}, 0);
      chk("rst_wen0", {31'b0, wen}, 0);
      chk("rst_wready0", {31'b0, wready}, 0);
      chk("rst_rvalid0", {31'b0, rvalid}, 0);
      chk("rst_done0", {31'b0, done}, 0);
      chk("rst_S_addr0", {27'b0, S_addr}, 0);
      chk("rst_S_din0", S_din, 0);
      chk("rst_rdata0", rdata, 0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++)
         burst(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].pat,
               vecs[i].base, vecs[i].exp_done);

      for (int i = 0; i < 16; i++)
         burst(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom_range(0, 9)),
               2, 8'h0, 32'h0, 0);

      busy_hold();
      reset_mid();

`ifdef RAM_MASTER_VERIFY_EN
      flip = 1'b1;
      burst(1'b1, 5'd12, 5'd1, 0, 8'h0, 32'h55, 6);
      flip = 1'b0;
      chk("err_set", {31'b0, err}, 1);
      burst(1'b0, 5'd12, 5'd1, 0, 8'h0, 32'h0, 4);
      chk("err_sticky", {31'b0, err}, 1);
      reset = 1'b1;
      #1;
      chk("err_cleared", {31'b0, err}, 0);
      step(); samp();
      reset = 1'b0;
`else
      burst(1'b1, 5'd12, 5'd1, 0, 8'h0, 32'h55, 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
